parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
Sequential, parametrised successor to the combinational 8-bit parity function. Accepts a stream of DATA_W-bit words grouped into frames via a valid/ready handshake. For each word it checks the received parity bit against the computed one, in even or odd mode. At end of frame it emits frame parity, word count and error summary on an output handshake, and keeps a saturating global error counter.

Parameters:
DATA_W, 8, data word width (>=1)
CNT_W, 8, width of word/error counters (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on first word of frame
clr_stats  input  1  synchronous clear of err_total
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  data word
in_par  input  1  received parity bit for in_data
in_last  input  1  word is last of frame
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts frame result
out_frame_par  output  1  frame parity (XOR of all frame data bits, XOR latched mode)
out_word_cnt  output  CNT_W  words in frame, saturating at all-ones
out_err_words  output  CNT_W  words with parity mismatch, saturating
out_err  output  1  1 if out_err_words != 0
err_total  output  CNT_W  mismatched words since reset/clear, saturating

Behaviour:
- Async reset, all outputs 0: in_ready=0 while rst_n low, state IDLE, all counters 0.
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. Accept = in_valid & in_ready.
- Word parity p = (XOR of in_data bits) XOR mode. Mismatch when p != in_par.
  - mode is odd_mode on the first word of a frame, latched value afterwards.
  - odd_mode changes mid-frame are ignored.
- IDLE + accept:
  - latch mode = odd_mode; acc = ^in_data; word_cnt = 1; err_words = mismatch.
  - in_last=1 -> HOLD, else ACCUM.
- ACCUM + accept:
  - acc ^= ^in_data; word_cnt++ (saturating); err_words += mismatch (saturating).
  - in_last=1 -> HOLD.
- No accept: state and accumulators unchanged.
- HOLD:
  - out_valid=1; out_frame_par = acc ^ mode; other outputs from frame registers.
  - Latency: out_valid rises the cycle after the last word is accepted.
  - Outputs stable while out_valid & !out_ready.
  - out_valid & out_ready -> IDLE; out_valid=0 next cycle.
  - A new word is accepted no earlier than the cycle after the handshake (no overlap).
- Single-word frame: IDLE -> HOLD directly.
- out_* hold last frame values after the handshake. Only out_valid qualifies them.
- err_total += mismatch on every accepted word, saturating at 2^CNT_W-1.
  - clr_stats forces err_total to 0 next edge, even if a mismatch word is accepted the same cycle (clear wins, that word is not counted).
- rst_n asserted mid-frame or in HOLD: frame discarded, all state cleared immediately.
- in_last ignored when no accept occurs.

Test Plan:
- Even mode, frame 0x01(par1), 0x03(par0), 0xFF(par0, last), out_ready=1 -> one cycle after last: out_valid=1, out_frame_par=1, out_word_cnt=3, out_err_words=0, out_err=0, err_total=0.
- Odd mode, single word 0x00 in_par=0 last -> word parity 1, mismatch. out_word_cnt=1, out_err_words=1, out_err=1, out_frame_par=1, err_total=1.
- Backpressure: complete frame, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs constant 3 cycles. Raise out_ready: IDLE next cycle, next word accepted the cycle after.
- Mode change mid-frame: start frame with odd_mode=0, flip to 1 on word 2 of 0x03,0x03(last) both par0 -> no errors, out_frame_par=0.
- Saturation/clear, CNT_W=2: 5 mismatched words in one frame -> out_err_words=3, err_total=3. Pulse clr_stats together with another mismatched accepted word -> err_total=0.
- Reset mid-frame: after 2 words, pulse rst_n low asynchronously (between edges) -> outputs 0 immediately. New frame 0x01(par1, last) -> out_word_cnt=1, out_err=0.

Source files
------------

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: per-word parity check over valid/ready framed words with frame summary output
//   clk, rst_n                 clock, async active-low reset
//   odd_mode, clr_stats        parity mode (sampled on first word), clear of err_total
//   in_valid/in_ready          word handshake with in_data, in_par, in_last
//   out_valid/out_ready        frame result handshake with out_frame_par, out_word_cnt, out_err_words, out_err
//   err_total                  saturating count of mismatched words since reset/clear
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_frame_par,
    output logic [CNT_W-1:0]  out_word_cnt,
    output logic [CNT_W-1:0]  out_err_words,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_total
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t             state_q;
    logic               in_ready_q, mode_q, acc_q, out_valid_q, out_frame_par_q;
    logic [CNT_W-1:0]   wcnt_q, ewords_q, out_word_cnt_q, out_err_words_q, err_total_q;
    logic               first, accept, word_par, mism, mode_d, acc_d;
    logic [CNT_W-1:0]   wcnt_d, ewords_d;
    assign first    = state_q == IDLE;
    assign accept   = in_valid & in_ready_q;
    assign word_par = ^in_data;
    // The mode is taken live only on the first word; later words use the latched one
    assign mode_d   = first ? odd_mode : mode_q;
    assign mism     = (word_par ^ mode_d) != in_par;
    assign acc_d    = first ? word_par : acc_q ^ word_par;
    assign wcnt_d   = first ? CNT_W'(1) : (&wcnt_q ? wcnt_q : wcnt_q + CNT_W'(1));
    assign ewords_d = first ? CNT_W'(mism) : ((mism && !(&ewords_q)) ? ewords_q + CNT_W'(1) : ewords_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b0;
            mode_q          <= 1'b0;
            acc_q           <= 1'b0;
            wcnt_q          <= '0;
            ewords_q        <= '0;
            out_valid_q     <= 1'b0;
            out_frame_par_q <= 1'b0;
            out_word_cnt_q  <= '0;
            out_err_words_q <= '0;
            err_total_q     <= '0;
        end else begin
            // Clear has priority over a mismatch counted in the same cycle
            err_total_q <= clr_stats ? '0
                         : (accept && mism && !(&err_total_q)) ? err_total_q + CNT_W'(1) : err_total_q;
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= !(accept && in_last);
                    if (accept) begin
                        mode_q   <= mode_d;
                        acc_q    <= acc_d;
                        wcnt_q   <= wcnt_d;
                        ewords_q <= ewords_d;
                        state_q  <= in_last ? HOLD : ACCUM;
                        if (in_last) begin
                            out_valid_q     <= 1'b1;
                            out_frame_par_q <= acc_d ^ mode_d;
                            out_word_cnt_q  <= wcnt_d;
                            out_err_words_q <= ewords_d;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_frame_par = out_frame_par_q;
    assign out_word_cnt  = out_word_cnt_q;
    assign out_err_words = out_err_words_q;
    assign out_err       = |out_err_words_q;
    assign err_total     = err_total_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: directed checks of parity_frame_checker at CNT_W=8 and CNT_W=2
module tb_parity_frame_checker;
    logic       clk = 1'b0, rst_n = 1'b0, odd_mode = 1'b0, clr_stats = 1'b0;
    logic       in_valid = 1'b0, in_par = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, out_frame_par, out_err;
    logic [7:0] out_word_cnt, out_err_words, err_total;
    logic       n_in_ready, n_out_valid, n_out_frame_par, n_out_err;
    logic [1:0] n_word_cnt, n_err_words, n_err_total;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_frame_par(out_frame_par),
        .out_word_cnt(out_word_cnt), .out_err_words(out_err_words), .out_err(out_err), .err_total(err_total)
    );

    parity_frame_checker #(.DATA_W(8), .CNT_W(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_par(in_par), .in_last(in_last),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_frame_par(n_out_frame_par),
        .out_word_cnt(n_word_cnt), .out_err_words(n_err_words), .out_err(n_out_err), .err_total(n_err_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [7:0] d, input logic p, input logic l, input logic m);
        in_valid = 1'b1; in_data = d; in_par = p; in_last = l; odd_mode = m;
    endtask

    task automatic idle;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_total", err_total, 0);
        chk("rst_n_err_total", n_err_total, 0);
        step; rst_n = 1'b1;
        step;
        chk("rdy_after_rst", in_ready, 1);
        // even frame 01/03/FF
        word(8'h01, 1, 0, 0); step;
        word(8'h03, 0, 0, 0); step;
        word(8'hFF, 0, 1, 0); out_ready = 1'b1; step;
        chk("t1_valid", out_valid, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_par", out_frame_par, 1);
        chk("t1_cnt", out_word_cnt, 3);
        chk("t1_errw", out_err_words, 0);
        chk("t1_err", out_err, 0);
        chk("t1_err_total", err_total, 0);
        idle; step;
        chk("t1_done_valid", out_valid, 0);
        chk("t1_done_ready", in_ready, 1);
        chk("t1_hold_cnt", out_word_cnt, 3);
        // odd single word mismatch
        word(8'h00, 0, 1, 1); step;
        chk("t2_valid", out_valid, 1);
        chk("t2_cnt", out_word_cnt, 1);
        chk("t2_errw", out_err_words, 1);
        chk("t2_err", out_err, 1);
        chk("t2_par", out_frame_par, 1);
        chk("t2_err_total", err_total, 1);
        idle; step;
        chk("t2_done_valid", out_valid, 0);
        // backpressure
        out_ready = 1'b0;
        word(8'h02, 1, 1, 0); step;
        word(8'h05, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_cnt", out_word_cnt, 1);
            chk("bp_par", out_frame_par, 1);
            if (i == 2) out_ready = 1'b1;
            step;
        end
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        step;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_par", out_frame_par, 0);
        chk("bp_next_cnt", out_word_cnt, 1);
        chk("bp_next_err_total", err_total, 1);
        idle; step;
        chk("bp_next_done", out_valid, 0);
        // mode flip mid-frame ignored
        word(8'h03, 0, 0, 0); step;
        word(8'h03, 0, 1, 1); step;
        chk("t4_par", out_frame_par, 0);
        chk("t4_errw", out_err_words, 0);
        chk("t4_err", out_err, 0);
        chk("t4_cnt", out_word_cnt, 2);
        idle; step;
        // saturation: five mismatched words
        for (int i = 0; i < 5; i++) begin
            word(8'h00, 1, i == 4, 0); step;
        end
        chk("sat_cnt_w", out_word_cnt, 5);
        chk("sat_cnt_n", n_word_cnt, 3);
        chk("sat_errw_w", out_err_words, 5);
        chk("sat_errw_n", n_err_words, 3);
        chk("sat_err_n", n_out_err, 1);
        chk("sat_total_w", err_total, 6);
        chk("sat_total_n", n_err_total, 3);
        idle; step;
        // clear wins over a simultaneous mismatch
        word(8'h00, 1, 1, 0); clr_stats = 1'b1; step;
        clr_stats = 1'b0;
        chk("clr_total_w", err_total, 0);
        chk("clr_total_n", n_err_total, 0);
        chk("clr_errw", out_err_words, 1);
        chk("clr_valid", out_valid, 1);
        idle; step;
        word(8'h00, 1, 1, 0); step;
        chk("post_clr_total", err_total, 1);
        idle; step;
        // async reset mid-frame
        word(8'h01, 1, 0, 0); step;
        word(8'h03, 0, 0, 0); step;
        idle;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", out_word_cnt, 0);
        chk("mid_rst_errw", out_err_words, 0);
        chk("mid_rst_total", err_total, 0);
        chk("mid_rst_total_n", n_err_total, 0);
        step; rst_n = 1'b1;
        step;
        chk("post_rst_ready", in_ready, 1);
        word(8'h01, 1, 1, 0); step;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_cnt", out_word_cnt, 1);
        chk("post_rst_err", out_err, 0);
        chk("post_rst_par", out_frame_par, 1);
        idle; step;
        chk("post_rst_done", out_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
